// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the
// MIPS datapath / shared memory port.
interface multicycle_sequencer_if #(
    parameter int CNT_W = 32
);
    logic [2:0]       inst_class;
    logic             except_in;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_wr;
    logic             addr_sel;
    logic             ir_we;
    logic             pc_we;
    logic             pc_src;
    logic             mdr_we;
    logic             rf_we;
    logic             addm_phase;
    logic             except;
    logic             timeout;
    logic [2:0]       state;
    logic [CNT_W-1:0] inst_count;

    // Sequencer side: takes decoder/memory status, drives all enables.
    modport slave (
        input  inst_class, except_in, mem_ready,
        output mem_req, mem_wr, addr_sel, ir_we, pc_we, pc_src, mdr_we,
               rf_we, addm_phase, except, timeout, state, inst_count
    );

    // Datapath/memory side.
    modport master (
        output inst_class, except_in, mem_ready,
        input  mem_req, mem_wr, addr_sel, ir_we, pc_we, pc_src, mdr_we,
               rf_we, addm_phase, except, timeout, state, inst_count
    );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback behind
// one variable-latency memory port, with memory timeout and halt-on-exception.
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    multicycle_sequencer_if.slave   bus
);
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXEC     = 3'd2,
        MEM_RD   = 3'd3,
        MEM_WR   = 3'd4,
        ADDM_ALU = 3'd5,
        WB       = 3'd6,
        HALT     = 3'd7
    } state_t;

    localparam logic [2:0] CLS_ALU    = 3'd0;
    localparam logic [2:0] CLS_LOAD   = 3'd1;
    localparam logic [2:0] CLS_STORE  = 3'd2;
    localparam logic [2:0] CLS_ADDM   = 3'd3;
    localparam logic [2:0] CLS_BRANCH = 3'd4;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    count_q;
    logic                timeout_q;
    logic                retire;
    logic                timeout_hit;
    logic                mem_state;
    logic                wait_expired;

    assign mem_state    = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign wait_expired = (wait_q == WAIT_W'(TIMEOUT - 1)) && !bus.mem_ready;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d        = state_q;
        retire         = 1'b0;
        timeout_hit    = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.addr_sel   = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 1'b0;
        bus.mdr_we     = 1'b0;
        bus.rf_we      = 1'b0;
        bus.addm_phase = 1'b0;
        bus.except     = 1'b0;

        // Outputs are forced low while reset is held so an in-flight access
        // is dropped immediately, not at the next edge.
        if (reset) begin
            unique case (state_q)
                FETCH: begin
                    bus.mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        bus.ir_we = 1'b1;
                        bus.pc_we = 1'b1;
                        state_d   = DECODE;
                    end else if (wait_expired) begin
                        timeout_hit = 1'b1;
                        state_d     = HALT;
                    end
                end
                DECODE: state_d = bus.except_in ? HALT : EXEC;
                EXEC: begin
                    case (bus.inst_class)
                        CLS_ALU:             state_d = WB;
                        CLS_LOAD, CLS_ADDM:  state_d = MEM_RD;
                        CLS_STORE:           state_d = MEM_WR;
                        CLS_BRANCH: begin
                            bus.pc_we  = 1'b1;
                            bus.pc_src = 1'b1;
                            retire     = 1'b1;
                            state_d    = FETCH;
                        end
                        default:             state_d = HALT;
                    endcase
                end
                MEM_RD: begin
                    bus.mem_req  = 1'b1;
                    bus.addr_sel = 1'b1;
                    if (bus.mem_ready) begin
                        bus.mdr_we = 1'b1;
                        state_d    = (bus.inst_class == CLS_ADDM) ? ADDM_ALU : WB;
                    end else if (wait_expired) begin
                        timeout_hit = 1'b1;
                        state_d     = HALT;
                    end
                end
                MEM_WR: begin
                    bus.mem_req  = 1'b1;
                    bus.mem_wr   = 1'b1;
                    bus.addr_sel = 1'b1;
                    if (bus.mem_ready) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else if (wait_expired) begin
                        timeout_hit = 1'b1;
                        state_d     = HALT;
                    end
                end
                ADDM_ALU: begin
                    bus.addm_phase = 1'b1;
                    state_d        = WB;
                end
                WB: begin
                    bus.rf_we      = 1'b1;
                    bus.addm_phase = (bus.inst_class == CLS_ADDM);
                    retire         = 1'b1;
                    state_d        = FETCH;
                end
                HALT:    bus.except = 1'b1;
                default: state_d = HALT;
            endcase
        end
    end

    // Wait counter only runs while stalled in a memory state; any completion
    // or state change restarts it.
    always_comb begin
        wait_d = '0;
        if (mem_state && !bus.mem_ready && (state_d == state_q))
            wait_d = wait_q + WAIT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)
                count_q <= count_q + CNT_W'(1);
            if (timeout_hit)
                timeout_q <= 1'b1;
        end
    end

    assign bus.timeout    = timeout_q;
    assign bus.state      = state_q;
    assign bus.inst_count = count_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: table-driven instruction mix
// through a scoreboard queue, plus hand-written stall/halt/reset sequences.
module tb_multicycle_sequencer;
    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();
    multicycle_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // flags order: mem_req mem_wr addr_sel ir_we pc_we pc_src mdr_we rf_we addm_phase except
    typedef struct {
        logic       ready;
        logic [2:0] cls;
        logic [2:0] exp_state;
        logic [9:0] exp_flags;
        int         exp_count;
    } vec_t;

    vec_t vecs[22];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic r, input logic [2:0] c, input logic [2:0] s,
                                input logic [9:0] f, input int n);
        vec_t v;
        v.ready = r; v.cls = c; v.exp_state = s; v.exp_flags = f; v.exp_count = n;
        return v;
    endfunction

    function automatic logic [9:0] flags();
        return {bus.mem_req, bus.mem_wr, bus.addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_src, bus.mdr_we, bus.rf_we, bus.addm_phase, bus.except};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle(input logic r, input logic [2:0] c, input logic e);
        @(negedge clock);
        bus.mem_ready  = r;
        bus.inst_class = c;
        bus.except_in  = e;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        int   rf_hi;
        int   viol;

        reset          = 1'b0;
        bus.mem_ready  = 1'b0;
        bus.inst_class = 3'd0;
        bus.except_in  = 1'b0;

        // Instruction mix with memory always ready: ALU, branch, load, store, addm.
        vecs[0]  = mk(1, 0, 0, 10'b1001100000, 0);
        vecs[1]  = mk(1, 0, 1, 10'b0000000000, 0);
        vecs[2]  = mk(1, 0, 2, 10'b0000000000, 0);
        vecs[3]  = mk(1, 0, 6, 10'b0000000100, 0);
        vecs[4]  = mk(1, 4, 0, 10'b1001100000, 1);
        vecs[5]  = mk(1, 4, 1, 10'b0000000000, 1);
        vecs[6]  = mk(1, 4, 2, 10'b0000110000, 1);
        vecs[7]  = mk(1, 1, 0, 10'b1001100000, 2);
        vecs[8]  = mk(1, 1, 1, 10'b0000000000, 2);
        vecs[9]  = mk(1, 1, 2, 10'b0000000000, 2);
        vecs[10] = mk(1, 1, 3, 10'b1010001000, 2);
        vecs[11] = mk(1, 1, 6, 10'b0000000100, 2);
        vecs[12] = mk(1, 2, 0, 10'b1001100000, 3);
        vecs[13] = mk(1, 2, 1, 10'b0000000000, 3);
        vecs[14] = mk(1, 2, 2, 10'b0000000000, 3);
        vecs[15] = mk(1, 2, 4, 10'b1110000000, 3);
        vecs[16] = mk(1, 3, 0, 10'b1001100000, 4);
        vecs[17] = mk(1, 3, 1, 10'b0000000000, 4);
        vecs[18] = mk(1, 3, 2, 10'b0000000000, 4);
        vecs[19] = mk(1, 3, 3, 10'b1010001000, 4);
        vecs[20] = mk(1, 3, 5, 10'b0000000010, 4);
        vecs[21] = mk(1, 3, 6, 10'b0000000110, 4);

        #12;
        check("rst_state",   32'(bus.state), 32'd0);
        check("rst_flags",   32'(flags()), 32'd0);
        check("rst_count",   bus.inst_count, 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        rf_hi = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            bus.mem_ready  = vecs[i].ready;
            bus.inst_class = vecs[i].cls;
            bus.except_in  = 1'b0;
            sb_q.push_back(vecs[i]);
            #2;
            e = sb_q.pop_front();
            check($sformatf("mix_state[%0d]", i), 32'(bus.state), 32'(e.exp_state));
            check($sformatf("mix_flags[%0d]", i), 32'(flags()), 32'(e.exp_flags));
            check($sformatf("mix_count[%0d]", i), bus.inst_count, 32'(e.exp_count));
            if (bus.rf_we) rf_hi++;
        end
        next_cycle(1, 0, 0);
        check("mix_end_state", 32'(bus.state), 32'd0);
        check("mix_end_count", bus.inst_count, 32'd5);
        check("mix_rf_we_cycles", 32'(rf_hi), 32'd3);

        // Load with memory stalled 3 cycles in MEM_RD.
        do_reset();
        next_cycle(1, 1, 0);
        next_cycle(1, 1, 0);
        next_cycle(1, 1, 0);
        check("ld_exec", 32'(bus.state), 32'd2);
        for (int k = 0; k < 4; k++) begin
            next_cycle(k == 3, 1, 0);
            check($sformatf("ld_wait_state[%0d]", k), 32'(bus.state), 32'd3);
            check($sformatf("ld_wait_req[%0d]", k), 32'({bus.mem_req, bus.addr_sel}), 32'b11);
            check($sformatf("ld_mdr_we[%0d]", k), 32'(bus.mdr_we), 32'(k == 3));
        end
        next_cycle(0, 1, 0);
        check("ld_wb_state", 32'(bus.state), 32'd6);
        check("ld_wb_rf_we", 32'(bus.rf_we), 32'd1);

        // Decoder exception halts until reset.
        do_reset();
        next_cycle(1, 0, 0);
        next_cycle(0, 0, 1);
        check("exc_decode", 32'(bus.state), 32'd1);
        next_cycle(1, 0, 0);
        check("exc_halt_state", 32'(bus.state), 32'd7);
        check("exc_halt_flag", 32'(bus.except), 32'd1);
        viol = 0;
        for (int k = 0; k < 20; k++) begin
            next_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (bus.mem_req || bus.pc_we || bus.state != 3'd7) viol++;
        end
        check("exc_halt_quiet", 32'(viol), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #2;
        check("exc_rst_state", 32'(bus.state), 32'd0);
        check("exc_rst_flag", 32'(bus.except), 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Reserved class in EXEC.
        do_reset();
        next_cycle(1, 6, 0);
        next_cycle(0, 6, 0);
        next_cycle(0, 6, 0);
        check("rsv_exec", 32'(bus.state), 32'd2);
        next_cycle(0, 6, 0);
        check("rsv_halt", 32'(bus.state), 32'd7);
        check("rsv_except", 32'(bus.except), 32'd1);
        check("rsv_timeout", 32'(bus.timeout), 32'd0);

        // Fetch timeout: FETCH re-entered after a branch, memory never ready.
        do_reset();
        next_cycle(1, 4, 0);
        next_cycle(0, 4, 0);
        next_cycle(0, 4, 0);
        viol = 0;
        for (int w = 1; w <= 16; w++) begin
            next_cycle(0, 0, 0);
            if (bus.state != 3'd0 || bus.timeout || !bus.mem_req) viol++;
        end
        check("to_waiting", 32'(viol), 32'd0);
        next_cycle(0, 0, 0);
        check("to_halt_state", 32'(bus.state), 32'd7);
        check("to_timeout", 32'(bus.timeout), 32'd1);
        check("to_except", 32'(bus.except), 32'd1);
        check("to_count", bus.inst_count, 32'd1);

        // Ready on the final waiting cycle beats the timeout.
        do_reset();
        next_cycle(1, 4, 0);
        next_cycle(0, 4, 0);
        next_cycle(0, 4, 0);
        for (int w = 1; w <= 15; w++) next_cycle(0, 0, 0);
        next_cycle(1, 0, 0);
        check("late_ir_we", 32'(bus.ir_we), 32'd1);
        next_cycle(0, 0, 0);
        check("late_decode", 32'(bus.state), 32'd1);
        check("late_timeout", 32'(bus.timeout), 32'd0);

        // Reset asserted between edges while a store is stalled.
        do_reset();
        next_cycle(1, 0, 0);
        next_cycle(0, 0, 0);
        next_cycle(0, 0, 0);
        next_cycle(0, 0, 0);
        next_cycle(1, 2, 0);
        next_cycle(0, 2, 0);
        next_cycle(0, 2, 0);
        next_cycle(0, 2, 0);
        check("st_memwr_state", 32'(bus.state), 32'd4);
        check("st_memwr_req", 32'({bus.mem_req, bus.mem_wr}), 32'b11);
        check("st_memwr_count", bus.inst_count, 32'd1);
        #1 reset = 1'b0;
        #1;
        check("st_rst_req", 32'({bus.mem_req, bus.mem_wr}), 32'b00);
        check("st_rst_count", bus.inst_count, 32'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        next_cycle(0, 0, 0);
        check("st_refetch_state", 32'(bus.state), 32'd0);
        check("st_refetch_addr", 32'({bus.mem_req, bus.addr_sel}), 32'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
